i2c_master_arbiter: RTL
=======================

I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: WAIT cycles allowed for done before abort; legal range 2..65535.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 req  in  2  per-requester transaction request; bit i belongs to requester i.
REQ-005 addr0, addr1  in  8  target address from requester 0 and 1.
REQ-006 wdata0, wdata1  in  8  write data from requester 0 and 1.
REQ-007 ack  out  2  one-cycle completion pulse to the granted requester.
REQ-008 rdata  out  8  captured master dataout; valid while ack is nonzero, then held.
REQ-009 err  out  1  timeout flag; valid while ack is nonzero, then held.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 master_addr  out  8  address driven to the I2C master.
REQ-012 data_in  out  8  data driven to the I2C master.
REQ-013 enable  out  1  one-cycle start strobe to the I2C master.
REQ-014 dataout  in  8  result byte from the I2C master.
REQ-015 done  in  1  I2C master completion strobe.

Function
REQ-016 FSM states: IDLE, LAUNCH, WAIT, RESP; all outputs registered.
REQ-017 IDLE: when any req bit is 1 at a rising edge, grant one requester, latch its addr/wdata, and go to LAUNCH.
REQ-018 Arbitration: single request wins; when both request, the requester not granted last wins.
REQ-019 LAUNCH: enable = 1 for exactly this one cycle, then go to WAIT.
REQ-020 master_addr/data_in hold the latched values from LAUNCH through RESP; inputs changing meanwhile have no effect.
REQ-021 WAIT: a counter starts at 0 and increments each cycle; done = 1 captures dataout into rdata, clears err and goes to RESP.
REQ-022 WAIT timeout: counter reaches TIMEOUT_CYCLES-1 with done = 0 -> rdata = 0x00, err = 1, go to RESP.
REQ-023 done and timeout in the same cycle: done wins and err = 0.
REQ-024 RESP: ack[granted] = 1 for exactly one cycle; last-grant pointer updated; return to IDLE.
REQ-025 done while in IDLE, LAUNCH or RESP is ignored.
REQ-026 Requester dropping req after grant does not cancel the transaction; ack is still pulsed.
REQ-027 Requester must drop req in the cycle after ack; a req still high in IDLE starts a new transaction.
REQ-028 Latency: req sampled at edge k -> enable high after edge k+1; done sampled at edge m -> ack high after edge m+1.
REQ-029 Back-to-back: minimum spacing between enable pulses is 4 cycles.

Reset
REQ-030 While rst = 0: state IDLE; ack, rdata, err, busy, master_addr, data_in and enable all 0; counter 0; pointer set so requester 0 wins the first tie.
REQ-031 rst asserted mid-transaction aborts immediately with no ack; the first transaction after release starts from IDLE.

Structure
REQ-032 Shared package i2c_arb_pkg holds the state enum, NUM_REQ = 2 and TIMEOUT_DEFAULT = 255.
REQ-033 One sub-module, i2c_rr_arb2, implements the 2-way round-robin grant and pointer (REQ-018, REQ-030); FSM, counter and datapath stay in the top level.

Verification
REQ-034 req = 01, addr0 = 0x10, wdata0 = 0x40; done pulsed 3 cycles after enable with dataout = 0xA5 -> master_addr = 0x10, data_in = 0x40, one enable pulse, ack = 01, rdata = 0xA5, err = 0.
REQ-035 req = 11 from reset, addr0 = 0x10, addr1 = 0x20, done returned each time -> requester 0 served first (ack = 01), then requester 1 (ack = 10); repeat with req = 11 -> grant order 0, 1, 0, 1.
REQ-036 TIMEOUT_CYCLES = 8, done never asserted -> ack pulses exactly 9 cycles after enable, err = 1, rdata = 0x00, busy drops the next cycle.
REQ-037 TIMEOUT_CYCLES = 8, done on the final WAIT cycle -> err = 0, rdata = dataout.
REQ-038 rst driven low during WAIT -> all outputs 0 asynchronously, no ack; a new req after release -> normal transaction.
REQ-039 done pulsed while in IDLE, and addr0 changed during WAIT -> no ack, and master_addr unchanged.

Source files
------------

// File: rtl/i2c_master_arbiter_pkg.sv
// Shared types and constants for the two-requester I2C master arbiter.
package i2c_arb_pkg;
   localparam int NUM_REQ         = 2;
   localparam int TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   function automatic logic [NUM_REQ-1:0] onehot(input logic idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction
endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Requester-side and I2C-master-side signals of the arbiter, bundled as one bus.
interface i2c_master_arbiter_if;
   import i2c_arb_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic [7:0]         addr0;
   logic [7:0]         addr1;
   logic [7:0]         wdata0;
   logic [7:0]         wdata1;
   logic [NUM_REQ-1:0] ack;
   logic [7:0]         rdata;
   logic               err;
   logic               busy;
   logic [7:0]         master_addr;
   logic [7:0]         data_in;
   logic               enable;
   logic [7:0]         dataout;
   logic               done;

   modport master (
      input  req, addr0, addr1, wdata0, wdata1, dataout, done,
      output ack, rdata, err, busy, master_addr, data_in, enable
   );

   modport slave (
      output req, addr0, addr1, wdata0, wdata1, dataout, done,
      input  ack, rdata, err, busy, master_addr, data_in, enable
   );
endinterface

// File: rtl/i2c_master_arbiter_rr.sv
// Two-way round-robin grant; the pointer remembers the last served requester.
module i2c_rr_arb2
   import i2c_arb_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               upd,
   input  logic               upd_idx,
   output logic               gnt_idx
);
   logic last;

   // Reset value 1 makes requester 0 win the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   last <= 1'b1;
      else if (upd) last <= upd_idx;
   end

   always_comb begin
      gnt_idx = 1'b0;
      case (req)
         2'b10:   gnt_idx = 1'b1;
         2'b11:   gnt_idx = ~last;
         default: gnt_idx = 1'b0;
      endcase
   end
endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C master between two requesters: grant, launch, wait for done or timeout, respond.
module i2c_master_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   i2c_master_arbiter_if.master bus
);
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t             state;
   state_t             next_state;
   logic [15:0]        cnt;
   logic               timeout;
   logic               gnt;
   logic               gnt_q;
   logic               enable_d;
   logic               busy_d;
   logic [NUM_REQ-1:0] ack_d;

   i2c_rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (bus.req),
      .upd     (state == RESP),
      .upd_idx (gnt_q),
      .gnt_idx (gnt)
   );

   assign timeout = (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (|bus.req) next_state = LAUNCH;
         LAUNCH:  next_state = WAIT;
         WAIT:    if (bus.done || timeout) next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Strobes are decoded from the current state and registered, so each lags its state by one cycle.
   always_comb begin
      enable_d = (state == LAUNCH);
      busy_d   = (state != IDLE);
      ack_d    = (state == RESP) ? onehot(gnt_q) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt             <= '0;
         gnt_q           <= 1'b0;
         bus.enable      <= 1'b0;
         bus.busy        <= 1'b0;
         bus.ack         <= '0;
         bus.rdata       <= '0;
         bus.err         <= 1'b0;
         bus.master_addr <= '0;
         bus.data_in     <= '0;
      end else begin
         bus.enable <= enable_d;
         bus.busy   <= busy_d;
         bus.ack    <= ack_d;
         cnt        <= (state == WAIT) ? cnt + 16'd1 : 16'd0;
         if (state == IDLE && |bus.req) begin
            gnt_q           <= gnt;
            bus.master_addr <= gnt ? bus.addr1  : bus.addr0;
            bus.data_in     <= gnt ? bus.wdata1 : bus.wdata0;
         end
         // done has priority over a timeout landing in the same cycle.
         if (state == WAIT) begin
            if (bus.done) begin
               bus.rdata <= bus.dataout;
               bus.err   <= 1'b0;
            end else if (timeout) begin
               bus.rdata <= 8'h00;
               bus.err   <= 1'b1;
            end
         end
      end
   end
endmodule
